mac_read_ctrl: RTL and testbench
================================

# mac_read_ctrl

Read-side controller for the MAC engine. After the write-side controller has loaded vector X (8 signed bytes) and coefficient vector M (3 signed bytes) into their memories, this block reads both memories and computes the 6-point valid convolution y[i] = Σ x[i+j]·m[j]. It streams each 16-bit result out over a valid/ready handshake. It is the reader that pairs with the existing loader; it shares the X/M memories and owns the downstream m_valid/m_ready interface.

## Interface
Parameters:
- XLEN, 8, entries in X memory
- MLEN, 3, entries in M memory (taps)
- DW, 8, data width of X/M entries (signed)
- OW, 16, output width (signed)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  memories loaded; begin a computation (sampled only in IDLE)
- x_rdata  in  8  X memory read data, valid 1 cycle after addr_X (synchronous read)
- m_rdata  in  8  M memory read data, valid 1 cycle after addr_M
- m_ready  in  1  downstream accepts data_out
- addr_X  out  4  X memory read address (registered)
- addr_M  out  2  M memory read address (registered)
- m_valid  out  1  data_out holds a result
- data_out  out  16  signed saturated result y[i]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- States: IDLE, ISSUE, DRAIN, OUTPUT.
- Counters: out index i (0..XLEN-MLEN = 0..5) and tap index k (0..2).
- IDLE:
  - On start=1: clear i, k, and the accumulator; go to ISSUE.
  - start in any other state is ignored; it is not queued.
- ISSUE, 3 cycles:
  - Drive addr_X=i+k and addr_M=k.
  - k increments each cycle.
  - After k=2, go to DRAIN.
- Accumulate path:
  - A read-valid flag delayed 1 cycle qualifies x_rdata·m_rdata.
  - The signed 16-bit product adds into an 18-bit signed accumulator. It cannot overflow: 3·128·128 = 49152.
- DRAIN, 1 cycle: accumulates the final product; go to OUTPUT.
- OUTPUT:
  - data_out is the accumulator saturated to 16-bit signed: >32767 → 32767, < −32768 → −32768.
  - m_valid=1. data_out and m_valid stay stable until m_valid&m_ready.
  - On handshake with i<5: i++, k=0, accumulator cleared, m_valid=0 next cycle, go to ISSUE.
  - On handshake with i=5: go to IDLE, done=1 for one cycle.
- Addresses:
  - Never exceed 7 (X) or 2 (M); no wrap-around is needed.
  - In IDLE and OUTPUT they hold their last value.
- Reset values: addr_X=0, addr_M=0, m_valid=0, data_out=0, busy=0, done=0, state IDLE.
- Reset asserted mid-computation aborts immediately. No result is emitted, and a new start is required.

## Timing
- Start is sampled at edge E0. ISSUE occupies cycles 1–3 and DRAIN cycle 4.
- m_valid rises in cycle 5, i.e. 5 cycles after the start edge.
- Per-result latency with m_ready held high: 5 cycles (3 ISSUE + 1 DRAIN + 1 OUTPUT).
- All 6 results complete in 30 cycles; done is high in cycle 31.
- Backpressure: each cycle of m_ready=0 in OUTPUT adds one cycle. No result is dropped or duplicated.
- m_ready while m_valid=0 has no effect.
- done and m_valid are never high in the same cycle.
- busy falls in the same cycle done rises.

## Test plan
- X = 1..8, M = {1,1,1}, m_ready=1. Expect data_out 6,9,12,15,18,21 on successive handshakes, m_valid first high 5 cycles after start, and done at cycle 31.
- X all −128, M all −128. Expect every data_out = 32767 (saturated from 49152). With X=−128 and M=127, expect −48768 saturating to −32768.
- X = {2,−3,4,0,0,0,0,5}, M = {1,0,−1}, m_ready toggled 0/1 randomly. Expect 2−4=−2, −3, 4, 0, 0, −5 in order; data_out stable while m_ready=0; exactly 6 handshakes.
- Pulse start while busy (cycle 10). Expect no restart and the sequence unchanged. Pulse start again after done. Expect a second full 6-result run.
- Assert reset during the third result's ISSUE. Expect m_valid, busy, addr_X and addr_M to be 0 immediately (asynchronous), no further m_valid, and a clean 6-result run on the next start.
- Check the address trace per result i. Expect addr_X = i, i+1, i+2 and addr_M = 0, 1, 2; addr_X never exceeds 7.

Source files
------------

// File: rtl/mac_read_ctrl.sv
// Read-side controller for the MAC engine: walks the X/M memories, computes the
// valid convolution y[i] = sum x[i+j]*m[j], and streams saturated results out.
module mac_read_ctrl #(
    parameter int XLEN = 8,
    parameter int MLEN = 3,
    parameter int DW   = 8,
    parameter int OW   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DW-1:0]              x_rdata,
    input  logic [DW-1:0]              m_rdata,
    input  logic                       m_ready,
    output logic [$clog2(XLEN):0]      addr_X,
    output logic [$clog2(MLEN)-1:0]    addr_M,
    output logic                       m_valid,
    output logic [OW-1:0]              data_out,
    output logic                       busy,
    output logic                       done
);
    localparam int XAW  = $clog2(XLEN) + 1;
    localparam int MAW  = $clog2(MLEN);
    localparam int NOUT = XLEN - MLEN + 1;
    localparam int PW   = 2 * DW;
    localparam int AW   = PW + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    state_t               state_q, state_d;
    logic [XAW-1:0]       i_q, i_d;
    logic [MAW-1:0]       k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d, acc_sum;
    logic signed [PW-1:0] prod;
    logic                 rd_vld_q, rd_vld_d;
    logic [XAW-1:0]       ax_q, ax_d;
    logic [MAW-1:0]       am_q, am_d;
    logic                 mv_q, mv_d;
    logic [OW-1:0]        dout_q, dout_d;
    logic                 done_q, done_d;

    // Clamp the wide accumulator into the signed output range.
    function automatic logic [OW-1:0] sat(input logic signed [AW-1:0] a);
        if (!a[AW-1] && (|a[AW-2:OW-1]))
            sat = {1'b0, {(OW-1){1'b1}}};
        else if (a[AW-1] && !(&a[AW-2:OW-1]))
            sat = {1'b1, {(OW-1){1'b0}}};
        else
            sat = a[OW-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        acc_d    = acc_q;
        ax_d     = ax_q;
        am_d     = am_q;
        mv_d     = mv_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        rd_vld_d = (state_q == ISSUE);

        // Read data lags the address by one cycle, so the valid flag does too.
        prod    = $signed(x_rdata) * $signed(m_rdata);
        acc_sum = acc_q + $signed({{(AW-PW){prod[PW-1]}}, prod});
        if (rd_vld_q)
            acc_d = acc_sum;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    ax_d    = '0;
                    am_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (k_q == MAW'(MLEN - 1)) begin
                    state_d = DRAIN;
                end else begin
                    k_d  = k_q + MAW'(1);
                    ax_d = i_q + XAW'(k_q) + XAW'(1);
                    am_d = k_q + MAW'(1);
                end
            end
            DRAIN: begin
                mv_d    = 1'b1;
                dout_d  = sat(acc_d);
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (mv_q && m_ready) begin
                    mv_d = 1'b0;
                    if (i_q == XAW'(NOUT - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        i_d     = i_q + XAW'(1);
                        k_d     = '0;
                        acc_d   = '0;
                        ax_d    = i_q + XAW'(1);
                        am_d    = '0;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            ax_q     <= '0;
            am_q     <= '0;
            mv_q     <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            rd_vld_q <= rd_vld_d;
            ax_q     <= ax_d;
            am_q     <= am_d;
            mv_q     <= mv_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign addr_X   = ax_q;
    assign addr_M   = am_q;
    assign m_valid  = mv_q;
    assign data_out = dout_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_mac_read_ctrl.sv
// Self-checking bench for mac_read_ctrl: memories modelled here, expected
// results computed directly from the convolution definition.
module tb_mac_read_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, m_ready;
    logic [7:0]  x_rdata, m_rdata;
    logic [3:0]  addr_X;
    logic [1:0]  addr_M;
    logic        m_valid, busy, done;
    logic [15:0] data_out;

    logic signed [7:0] xmem [8];
    logic signed [7:0] mmem [3];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mac_read_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_rdata  (x_rdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .addr_X   (addr_X),
        .addr_M   (addr_M),
        .m_valid  (m_valid),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories.
    always @(posedge clk) begin
        x_rdata <= xmem[addr_X[2:0]];
        m_rdata <= mmem[addr_M];
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load(input int x[8], input int m[3]);
        for (int a = 0; a < 8; a++) xmem[a] = 8'(x[a]);
        for (int a = 0; a < 3; a++) mmem[a] = 8'(m[a]);
    endtask

    task automatic load_rand();
        for (int a = 0; a < 8; a++) xmem[a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 3; a++) mmem[a] = 8'($urandom_range(0, 255));
    endtask

    // One full computation; optionally random backpressure, a stray start
    // at cycle 10, or a reset during the third result's issue phase.
    task automatic run(input bit rnd_ready, input bit poke, input bit abort);
        int  exp[6];
        int  i = 0, n = 0, cyc = 0, stalls = 0;
        bit  fin = 0;
        for (int r = 0; r < 6; r++) begin
            int s = 0;
            for (int j = 0; j < 3; j++) s += int'(xmem[r+j]) * int'(mmem[j]);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp[r] = s;
        end
        @(negedge clk);
        start = 1'b1;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            n++;
            if (poke && cyc == 10) start = 1'b1;
            if (abort && i == 2 && n == 2) begin
                reset = 1'b1;
                #1;
                chk("abort_mvalid", m_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_addrX", addr_X, 0);
                chk("abort_addrM", addr_M, 0);
                @(negedge clk);
                reset = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    chk("post_abort_mvalid", m_valid, 0);
                    chk("post_abort_busy", busy, 0);
                end
                return;
            end
            if (n >= 1 && n <= 3) begin
                chk("addrX_trace", addr_X, i + n - 1);
                chk("addrM_trace", addr_M, n - 1);
            end
            chk("mvalid_timing", m_valid, (n >= 5) ? 1 : 0);
            chk("busy_running", busy, 1);
            chk("done_low", done, 0);
            if (m_valid) chk($sformatf("data_y%0d", i), $signed(data_out), exp[i]);
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                i++;
                n = 0;
                if (i == 6) fin = 1;
            end else if (m_valid) begin
                stalls++;
            end
        end
        chk("run_completed", fin, 1);
        chk("handshakes", i, 6);
        @(negedge clk);
        cyc++;
        m_ready = 1'b1;
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("mvalid_after", m_valid, 0);
        chk("done_cycle", cyc, 31 + stalls);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_mvalid", m_valid, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
        for (int a = 0; a < 8; a++) xmem[a] = '0;
        for (int a = 0; a < 3; a++) mmem[a] = '0;
        repeat (2) @(negedge clk);
        chk("rst_addrX", addr_X, 0);
        chk("rst_addrM", addr_M, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready_no_effect", m_valid, 0);

        load('{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 1, 1});
        run(0, 0, 0);
        load('{-128, -128, -128, -128, -128, -128, -128, -128}, '{-128, -128, -128});
        run(0, 0, 0);
        load('{-128, -128, -128, -128, -128, -128, -128, -128}, '{127, 127, 127});
        run(0, 0, 0);
        load('{2, -3, 4, 0, 0, 0, 0, 5}, '{1, 0, -1});
        run(1, 0, 0);
        run(1, 1, 0);
        run(0, 0, 0);
        load_rand();
        run(1, 0, 1);
        run(1, 0, 0);
        for (int t = 0; t < 6; t++) begin
            load_rand();
            run(1, (t % 2) == 1, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
